// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - register offsets inside the 16-byte window
//   - STATUS register bit positions
//   - serialiser FSM state encoding
package mmio_uart_pkg;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] BAUD_OFS   = 4'h8;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with show-ahead read port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and data
//   pop                 read request; pop_data is the head entry before the pop
//   full, empty         occupancy flags from registered state
// Handshake: push is accepted when the FIFO is not full, or when it is full
// and a pop is accepted in the same cycle (occupancy then stays at DEPTH).
// pop is accepted only when the FIFO is not empty. A refused push is simply
// dropped; the caller decides what to do about it.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   memAddress, memWriteData   CPU byte address and write data
//   memWrite, byteMask         one-cycle write strobe, per-lane byte enables
//   memReadData                registered read data, zero outside the window
//   txd                        serial line, idles high
//   tx_irq                     high when nothing is queued or in flight
//   dbg_state                  serialiser FSM state
// Register map (offset = memAddress[3:0]):
//   0x0 TXDATA  write pushes byte lane 0 into the TX FIFO, reads 0
//   0x4 STATUS  {overflow, empty, full, busy}; writing 1 to bit 3 clears overflow
//   0x8 BAUD    bit period minus one, in clk cycles, per-lane writable
//   0xC reserved, reads 0
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  input  logic        memWrite,
  input  logic [3:0]  byteMask,
  output logic [31:0] memReadData,
  output logic        txd,
  output logic        tx_irq,
  output tx_state_t   dbg_state
);

  // Bus decode
  logic       hit;
  logic [3:0] ofs;
  logic       wr_en;

  assign hit   = (memAddress[31:4] == BASE_ADDR[31:4]);
  assign ofs   = memAddress[3:0];
  assign wr_en = hit & memWrite;

  // Upper write lanes have no register behind them.
  logic unused_lanes;
  assign unused_lanes = ^{memWriteData[31:16], byteMask[3:2]};

  // FIFO interface
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_data;

  assign fifo_push = wr_en & (ofs == TXDATA_OFS) & byteMask[0];

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (memWriteData[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Registers
  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] baud_lat_q, baud_lat_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        txd_q, txd_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;

  logic busy;
  logic bit_done;

  assign busy        = (state_q != IDLE);
  assign bit_done    = (cnt_q == 16'd0);
  assign tx_irq      = fifo_empty & ~busy;
  assign txd         = txd_q;
  assign memReadData = rdata_q;
  assign dbg_state   = state_q;

  // CPU-visible register updates and read mux
  always_comb begin
    baud_d  = baud_q;
    ovf_d   = ovf_q;
    rdata_d = 32'd0;

    if (wr_en && (ofs == BAUD_OFS)) begin
      if (byteMask[0]) baud_d[7:0]  = memWriteData[7:0];
      if (byteMask[1]) baud_d[15:8] = memWriteData[15:8];
    end

    // A dropped byte in the same cycle as a clear leaves the flag set, so
    // the loss is never hidden.
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (wr_en && (ofs == STATUS_OFS) && byteMask[0] &&
                 memWriteData[STAT_OVF]) begin
      ovf_d = 1'b0;
    end

    if (hit) begin
      case (ofs)
        STATUS_OFS: begin
          rdata_d[STAT_BUSY]  = busy;
          rdata_d[STAT_FULL]  = fifo_full;
          rdata_d[STAT_EMPTY] = fifo_empty;
          rdata_d[STAT_OVF]   = ovf_q;
        end
        BAUD_OFS: rdata_d = {16'd0, baud_q};
        default:  rdata_d = 32'd0;
      endcase
    end
  end

  // Serialiser FSM. txd is registered, so the value chosen here appears on
  // the line from the next edge; each state therefore sets up the level of
  // the bit that follows it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    baud_lat_d = baud_lat_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    txd_d      = txd_q;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_data;
          baud_lat_d = baud_q;
          cnt_d      = baud_q;
          txd_d      = 1'b0;
          state_d    = START;
        end
      end

      START: begin
        if (bit_done) begin
          cnt_d   = baud_lat_q;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      DATA: begin
        if (bit_done) begin
          cnt_d = baud_lat_q;
          if (idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      STOP: begin
        if (bit_done) begin
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_data;
            baud_lat_d = baud_q;
            cnt_d      = baud_q;
            txd_d      = 1'b0;
            state_d    = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      baud_q     <= DEFAULT_DIV;
      baud_lat_q <= DEFAULT_DIV;
      shift_q    <= 8'd0;
      idx_q      <= 3'd0;
      txd_q      <= 1'b1;
      ovf_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      baud_q     <= baud_d;
      baud_lat_q <= baud_lat_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      txd_q      <= txd_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus driver tasks, a mid-bit txd sampler feeding a
// byte scoreboard, a table of register-access vectors and hand-written
// frame sequences.
module tb_mmio_uart_tx;
  import mmio_uart_pkg::*;

  localparam int PER = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memAddress = 32'd0;
  logic [31:0] memWriteData = 32'd0;
  logic        memWrite = 1'b0;
  logic [3:0]  byteMask = 4'd0;
  logic [31:0] memReadData;
  logic        txd;
  logic        tx_irq;
  tx_state_t   dbg_state;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   bit_cycles = 4;
  logic mon_en = 1'b0;

  logic [7:0] exp_q[$];
  int         start_cyc_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  mask;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0001_0000),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .byteMask     (byteMask),
    .memReadData  (memReadData),
    .txd          (txd),
    .tx_irq       (tx_irq),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #(PER/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(500_000);
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive before the edge, capture read data just after it.
  // edge_n is the cycle number of the edge that sampled the request.
  task automatic bus_op(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [3:0] m, output logic [31:0] rd, output int edge_n);
    @(negedge clk);
    memAddress   = a;
    memWriteData = d;
    memWrite     = we;
    byteMask     = m;
    @(posedge clk);
    #1;
    rd       = memReadData;
    edge_n   = cyc;
    memWrite = 1'b0;
    byteMask = 4'd0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, output int edge_n);
    logic [31:0] rd;
    bus_op(a, d, 1'b1, m, rd, edge_n);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
    int n;
    bus_op(a, 32'd0, 1'b0, 4'd0, rd, n);
  endtask

  // Returns the cycle of the edge after which tx_irq is high again.
  task automatic wait_idle(input int max_cyc, output int c);
    c = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk);
      #1;
      if (tx_irq === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: tx_irq still low after %0d cycles", max_cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic we,
                              input logic [3:0] m, input logic chk, input logic [31:0] e);
    vec_t v;
    v.addr  = a;
    v.wdata = d;
    v.we    = we;
    v.mask  = m;
    v.chk   = chk;
    v.exp   = e;
    return v;
  endfunction

  // txd sampler: finds a start bit, samples every bit at mid-period and
  // checks the byte against the scoreboard.
  initial begin : sampler
    logic [7:0] rx;
    logic [7:0] e;
    logic       st, sp;
    int         p, h;
    forever begin
      @(negedge clk);
      if (mon_en && reset === 1'b1 && txd === 1'b0) begin
        start_cyc_q.push_back(cyc);
        p = bit_cycles;
        h = (p - 1) / 2;
        repeat (h) @(negedge clk);
        st = txd;
        for (int b = 0; b < 8; b++) begin
          repeat (p) @(negedge clk);
          rx[b] = txd;
        end
        repeat (p) @(negedge clk);
        sp = txd;
        check("start_bit", {31'd0, st}, 32'd0);
        check("stop_bit", {31'd0, sp}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got byte %h, none expected", rx);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", {24'd0, rx}, {24'd0, e});
        end
      end
    end
  end

  initial begin : main
    logic [31:0] rd;
    int          n, n0, c, busy_bad;

    // Reset state, both during and after reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, tx_irq}, 32'd1);
    check("rst_rdata", memReadData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_state", 32'(dbg_state), 32'(IDLE));
    check("rel_txd", {31'd0, txd}, 32'd1);
    mon_en = 1'b1;

    // Register-access vectors, all with the serialiser idle
    vq.push_back(mk(32'h0001_0004, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h4));
    vq.push_back(mk(32'h0001_0008, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h3));
    vq.push_back(mk(32'h0001_0000, 32'h0000_00AA, 1'b1, 4'b0010, 1'b0, 32'h0));
    vq.push_back(mk(32'h0001_0004, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h4));
    vq.push_back(mk(32'h0001_0000, 32'h0000_0011, 1'b0, 4'b1111, 1'b0, 32'h0));
    vq.push_back(mk(32'h0001_0004, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h4));
    vq.push_back(mk(32'h0001_0008, 32'h0000_0010, 1'b1, 4'b0011, 1'b0, 32'h0));
    vq.push_back(mk(32'h0001_0008, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h10));
    vq.push_back(mk(32'h0001_0008, 32'h0000_AB77, 1'b1, 4'b0010, 1'b0, 32'h0));
    vq.push_back(mk(32'h0001_0008, 32'd0,         1'b0, 4'b0000, 1'b1, 32'hAB10));
    vq.push_back(mk(32'h0001_0008, 32'hFFFF_0003, 1'b1, 4'b0001, 1'b0, 32'h0));
    vq.push_back(mk(32'h0001_0008, 32'd0,         1'b0, 4'b0000, 1'b1, 32'hAB03));
    vq.push_back(mk(32'h0001_000C, 32'hFFFF_FFFF, 1'b1, 4'b1111, 1'b0, 32'h0));
    vq.push_back(mk(32'h0001_000C, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h0));
    vq.push_back(mk(32'h0001_0000, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h0));
    vq.push_back(mk(32'h0001_0024, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h0));
    vq.push_back(mk(32'h0001_0020, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h0));
    vq.push_back(mk(32'h0001_0028, 32'h0000_1234, 1'b1, 4'b0011, 1'b0, 32'h0));
    vq.push_back(mk(32'h0001_0008, 32'd0,         1'b0, 4'b0000, 1'b1, 32'hAB03));
    vq.push_back(mk(32'h0001_0008, 32'h0000_0003, 1'b1, 4'b0011, 1'b0, 32'h0));
    vq.push_back(mk(32'h0001_0008, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h3));
    vq.push_back(mk(32'h0001_0004, 32'd0,         1'b0, 4'b0000, 1'b1, 32'h4));
    for (int i = 0; i < vq.size(); i++) begin
      bus_op(vq[i].addr, vq[i].wdata, vq[i].we, vq[i].mask, rd, n);
      if (vq[i].chk) check($sformatf("vec%0d", i), rd, vq[i].exp);
    end

    // Single byte 0x55, 4-cycle bits
    bit_cycles = 4;
    exp_q.push_back(8'h55);
    bus_write(32'h0001_0000, 32'h55, 4'b0001, n);
    check("sb_state_at_write", 32'(dbg_state), 32'(IDLE));
    check("sb_txd_at_write", {31'd0, txd}, 32'd1);
    check("sb_irq_at_write", {31'd0, tx_irq}, 32'd0);
    @(posedge clk);
    #1;
    check("sb_start_edge_txd", {31'd0, txd}, 32'd0);
    check("sb_start_edge_state", 32'(dbg_state), 32'(START));
    busy_bad = 0;
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (tx_irq !== 1'b0 || dbg_state == IDLE) busy_bad++;
    end
    check("sb_busy_through_frame", busy_bad, 0);
    @(posedge clk);
    #1;
    check("sb_irq_after_stop", {31'd0, tx_irq}, 32'd1);
    check("sb_frame_end_cycle", cyc, n + 41);
    check("sb_start_cycle", start_cyc_q[start_cyc_q.size()-1], n + 1);

    // Overflow: 10 back-to-back pushes into an 8-deep FIFO
    start_cyc_q.delete();
    n0 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(i));
      bus_write(32'h0001_0000, 32'(i), 4'b0001, n);
      if (i == 0) n0 = n;
    end
    bus_read(32'h0001_0004, rd);
    check("ovf_status", rd, 32'hB);  // busy | full | overflow
    bus_write(32'h0001_0004, 32'h8, 4'b0001, n);
    bus_read(32'h0001_0004, rd);
    check("ovf_cleared_status", rd, 32'h3);
    wait_idle(1000, c);
    check("ovf_drain_end", c, n0 + 1 + 9 * 40);
    check("ovf_frame_count", start_cyc_q.size(), 9);
    for (int k = 0; k < start_cyc_q.size(); k++)
      check($sformatf("ovf_frame%0d_start", k), start_cyc_q[k], n0 + 1 + 40 * k);
    bus_read(32'h0001_0004, rd);
    check("ovf_status_after_drain", rd, 32'h4);

    // BAUD = 16: 17-cycle bits; a BAUD write mid-frame waits for the next frame
    bus_write(32'h0001_0008, 32'h0010, 4'b0011, n);
    bus_read(32'h0001_0008, rd);
    check("baud16_readback", rd, 32'h10);
    bit_cycles = 17;
    exp_q.push_back(8'hC3);
    bus_write(32'h0001_0000, 32'hC3, 4'b0001, n0);
    repeat (20) @(posedge clk);
    bus_write(32'h0001_0008, 32'h0000, 4'b0011, n);
    bus_read(32'h0001_0008, rd);
    check("baud0_readback", rd, 32'h0);
    wait_idle(400, c);
    check("baud16_frame_end", c, n0 + 1 + 170);

    // BAUD = 0: 1-cycle bits
    bit_cycles = 1;
    exp_q.push_back(8'h96);
    bus_write(32'h0001_0000, 32'h96, 4'b0001, n);
    wait_idle(100, c);
    check("baud0_frame_end", c, n + 11);
    bus_write(32'h0001_0008, 32'h0003, 4'b0011, n);
    bit_cycles = 4;

    // Reset in the middle of DATA bit 3 of 0xF0 (a 0 bit on the line)
    mon_en = 1'b0;
    bus_write(32'h0001_0008, 32'h0010, 4'b0011, n);  // non-default BAUD before reset
    bus_write(32'h0001_0008, 32'h0003, 4'b0011, n);
    bus_write(32'h0001_0000, 32'hF0, 4'b0001, n);
    bus_write(32'h0001_0000, 32'hA5, 4'b0001, n0);   // queued, must be flushed
    bus_write(32'h0001_0008, 32'h0020, 4'b0011, n0); // reset must restore BAUD
    repeat (17 - 2) @(posedge clk);
    @(negedge clk);
    check("mr_state_before", 32'(dbg_state), 32'(DATA));
    check("mr_txd_before", {31'd0, txd}, 32'd0);
    reset = 1'b0;
    #1;
    check("mr_txd_in_reset", {31'd0, txd}, 32'd1);
    check("mr_irq_in_reset", {31'd0, tx_irq}, 32'd1);
    check("mr_state_in_reset", 32'(dbg_state), 32'(IDLE));
    check("mr_rdata_in_reset", memReadData, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus_read(32'h0001_0004, rd);
    check("mr_status_after", rd, 32'h4);
    bus_read(32'h0001_0008, rd);
    check("mr_baud_after", rd, 32'h3);
    mon_en = 1'b1;
    exp_q.push_back(8'h3C);
    bus_write(32'h0001_0000, 32'h3C, 4'b0001, n);
    wait_idle(100, c);
    check("mr_new_frame_end", c, n + 41);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
